// File: rtl/mux_sel_arbiter.sv
// Four-channel round-robin arbiter that owns the 2-bit select of a shared 4:1 mux.
// Grants are held until done, withdrawal, or a hold timeout, with zero-bubble regrant.
module mux_sel_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       hold_expired
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  logic [0:0]       state;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       timeout;
  logic       release_now;

  // Scan from ptr+4 down to ptr+1 so the nearest requester after ptr overwrites the rest.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  always_comb begin
    winner      = pick(req, rr_ptr);
    any_req     = |req;
    owner_req   = req[sel];
    timeout     = (hold_cnt == HOLD_LAST);
    release_now = done | ~owner_req | timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel          <= 2'b00;
      gnt          <= 4'b0000;
      gnt_valid    <= 1'b0;
      hold_expired <= 1'b0;
      hold_cnt     <= '0;
      rr_ptr       <= 2'd3;
    end else begin
      hold_expired <= 1'b0;
      case (state)
        ST_IDLE: begin
          // sel is left alone here so the mux select does not glitch while idle.
          if (any_req) begin
            state     <= ST_GRANT;
            sel       <= winner;
            gnt       <= 4'b0001 << winner;
            gnt_valid <= 1'b1;
            rr_ptr    <= winner;
            hold_cnt  <= '0;
          end
        end
        ST_GRANT: begin
          if (!release_now) begin
            if (hold_cnt != CNT_SAT) hold_cnt <= hold_cnt + 1'b1;
          end else begin
            // Only a pure timeout counts as expiry; done or withdrawal take precedence.
            hold_expired <= timeout & ~done & owner_req;
            if (any_req) begin
              sel      <= winner;
              gnt      <= 4'b0001 << winner;
              rr_ptr   <= winner;
              hold_cnt <= '0;
            end else begin
              state     <= ST_IDLE;
              gnt       <= 4'b0000;
              gnt_valid <= 1'b0;
              hold_cnt  <= '0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          gnt       <= 4'b0000;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

endmodule
